// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU front end.
package cpu_pkg;

  localparam int unsigned IDX_W       = 8;
  localparam int unsigned DEF_INSTR_W = 16;

  typedef logic [IDX_W-1:0] instr_idx_t;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_FETCH,
    IFU_DRAIN,
    IFU_DONE
  } ifu_state_t;

endpackage

// File: rtl/ifu_skid_fifo.sv
// Two-entry in-order buffer between instruction memory return and decode.
// The head entry is a register, so downstream never sees memory data combinationally.
module ifu_skid_fifo #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             valid
);

  logic [WIDTH-1:0] tail;

  assign valid = (count != 2'd0);

  // The head always holds the oldest entry; tail only fills when the head is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: walks the index from START_INDEX to LAST_INDEX,
// reads the 1-cycle-latency instruction memory and hands words to decode in order.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W     = DEF_INSTR_W,
  parameter instr_idx_t  LAST_INDEX  = 8'hFF,
  parameter instr_idx_t  START_INDEX = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [7:0]         imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [7:0]         instr_index,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ENTRY_W = IDX_W + INSTR_W;

  ifu_state_t   state;
  ifu_state_t   state_next;
  instr_idx_t   pc;
  instr_idx_t   pc_next;
  instr_idx_t   issued_idx;
  logic         inflight;
  logic         issue;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  logic [2:0]   occupancy;
  logic [2:0]   count_next;
  logic [ENTRY_W-1:0] head;

  assign pop        = instr_valid & instr_ready;
  assign push       = inflight;
  assign occupancy  = 3'(count) + 3'(inflight);
  assign count_next = occupancy - 3'(pop);

  // Credit check: never let buffered + outstanding words exceed the two FIFO slots.
  assign issue = (state == IFU_FETCH) && !reset && (occupancy < (3'd2 + 3'(pop)));

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IFU_IDLE, IFU_DONE: begin
        if (start) begin
          pc_next    = START_INDEX;
          state_next = (START_INDEX > LAST_INDEX) ? IFU_DONE : IFU_FETCH;
        end
      end
      IFU_FETCH: begin
        if (issue) begin
          if (pc == LAST_INDEX) state_next = IFU_DRAIN;
          else                  pc_next    = pc + 8'd1;
        end
      end
      IFU_DRAIN: begin
        // No reads are issued here, so an empty buffer next cycle means nothing is left.
        if (count_next == 3'd0) state_next = IFU_DONE;
      end
      default: state_next = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IFU_IDLE;
      pc         <= START_INDEX;
      inflight   <= 1'b0;
      issued_idx <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      inflight <= issue;
      if (issue) issued_idx <= pc;
    end
  end

  ifu_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({issued_idx, imem_rdata}),
    .head  (head),
    .count (count),
    .valid (instr_valid)
  );

  assign imem_rd_en  = issue;
  assign imem_addr   = pc;
  assign instr_index = head[ENTRY_W-1 -: IDX_W];
  assign instr_data  = head[INSTR_W-1:0];
  assign busy        = (state == IFU_FETCH) || (state == IFU_DRAIN);
  assign done        = (state == IFU_DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: three configurations (full range, short program,
// empty range) against an in-order scoreboard and cycle-exact expectations.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: LAST_INDEX=8'hFF
  logic rst_a, start_a, rd_en_a, valid_a, ready_a, busy_a, done_a;
  logic [7:0] addr_a, idx_a;
  logic [15:0] rdata_a, data_a;
  // Instance B: LAST_INDEX=3
  logic rst_b, start_b, rd_en_b, valid_b, ready_b, busy_b, done_b;
  logic [7:0] addr_b, idx_b;
  logic [15:0] rdata_b, data_b;
  // Instance C: START_INDEX=8'h10, LAST_INDEX=8'h0F
  logic rst_c, start_c, rd_en_c, valid_c, ready_c, busy_c, done_c;
  logic [7:0] addr_c, idx_c;
  logic [15:0] rdata_c, data_c;

  instr_fetch_unit #(.INSTR_W(16), .LAST_INDEX(8'hFF), .START_INDEX(8'h00)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .imem_rd_en(rd_en_a), .imem_addr(addr_a),
    .imem_rdata(rdata_a), .instr_valid(valid_a), .instr_ready(ready_a), .instr_data(data_a),
    .instr_index(idx_a), .busy(busy_a), .done(done_a));

  instr_fetch_unit #(.INSTR_W(16), .LAST_INDEX(8'h03), .START_INDEX(8'h00)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .imem_rd_en(rd_en_b), .imem_addr(addr_b),
    .imem_rdata(rdata_b), .instr_valid(valid_b), .instr_ready(ready_b), .instr_data(data_b),
    .instr_index(idx_b), .busy(busy_b), .done(done_b));

  instr_fetch_unit #(.INSTR_W(16), .LAST_INDEX(8'h0F), .START_INDEX(8'h10)) u_dut_c (
    .clk(clk), .reset(rst_c), .start(start_c), .imem_rd_en(rd_en_c), .imem_addr(addr_c),
    .imem_rdata(rdata_c), .instr_valid(valid_c), .instr_ready(ready_c), .instr_data(data_c),
    .instr_index(idx_c), .busy(busy_c), .done(done_c));

  // Instruction memory models: word at index i is {8'hA5, i}, one cycle after the read.
  always @(posedge clk) if (rd_en_a) rdata_a <= {8'hA5, addr_a};
  always @(posedge clk) if (rd_en_b) rdata_b <= {8'hA5, addr_b};
  always @(posedge clk) if (rd_en_c) rdata_c <= {8'hA5, addr_c};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for A: reads must be consecutive, deliveries in order, never >2 pending.
  int          a_exp_iss, a_exp_pop, a_n_iss, a_n_pop;
  logic        a_stall;
  logic [15:0] a_prev_data;
  logic [7:0]  a_prev_idx;
  logic        c_rd_seen;

  task automatic a_clear();
    a_exp_iss = 0;
    a_exp_pop = 0;
    a_n_iss   = 0;
    a_n_pop   = 0;
    a_stall   = 1'b0;
  endtask

  task automatic mon_a();
    if (rst_a) begin
      a_clear();
    end else begin
      if (a_stall) begin
        check("a_stall_valid", 32'(valid_a), 32'd1);
        check("a_stall_index", 32'(idx_a), 32'(a_prev_idx));
        check("a_stall_data", 32'(data_a), 32'(a_prev_data));
      end
      if (rd_en_a) begin
        check("a_issue_addr", 32'(addr_a), 32'(a_exp_iss));
        check("a_issue_range", 32'(a_exp_iss <= 255), 32'd1);
        a_exp_iss++;
        a_n_iss++;
      end
      if (valid_a && ready_a) begin
        check("a_pop_index", 32'(idx_a), 32'(a_exp_pop));
        check("a_pop_data", 32'(data_a), 32'({8'hA5, 8'(a_exp_pop)}));
        a_exp_pop++;
        a_n_pop++;
      end
      check("a_outstanding", 32'((a_n_iss - a_n_pop) <= 2), 32'd1);
      a_stall     = valid_a && !ready_a;
      a_prev_idx  = idx_a;
      a_prev_data = data_a;
    end
  endtask

  // Inputs are changed at the falling edge; the monitors sample just after that.
  task automatic tick();
    #1;
    mon_a();
    if (!rst_c && rd_en_c) c_rd_seen = 1'b1;
    @(negedge clk);
  endtask

  // Short program on B: start, spurious start while fetching, cycle-exact expectations.
  task automatic run_b(input string tag);
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    for (int n = 0; n < 8; n++) begin
      start_b = (n == 1);
      check($sformatf("%s_valid_c%0d", tag, n), 32'(valid_b), 32'(n >= 2 && n <= 5));
      if (n >= 2 && n <= 5) begin
        check($sformatf("%s_index_c%0d", tag, n), 32'(idx_b), 32'(n - 2));
        check($sformatf("%s_data_c%0d", tag, n), 32'(data_b), 32'({8'hA5, 8'(n - 2)}));
      end
      check($sformatf("%s_rd_en_c%0d", tag, n), 32'(rd_en_b), 32'(n <= 3));
      if (n <= 3) check($sformatf("%s_addr_c%0d", tag, n), 32'(addr_b), 32'(n));
      check($sformatf("%s_busy_c%0d", tag, n), 32'(busy_b), 32'(n <= 5));
      check($sformatf("%s_done_c%0d", tag, n), 32'(done_b), 32'(n >= 6));
      tick();
    end
    start_b = 1'b0;
  endtask

  initial begin
    {rst_a, rst_b, rst_c} = 3'b111;
    {start_a, start_b, start_c} = 3'b000;
    {ready_a, ready_b, ready_c} = 3'b000;
    c_rd_seen = 1'b0;
    a_clear();
    @(negedge clk);
    repeat (3) tick();
    {rst_a, rst_b, rst_c} = 3'b000;
    tick();

    // Reset state
    check("rst_a_valid", 32'(valid_a), 32'd0);
    check("rst_a_busy", 32'(busy_a), 32'd0);
    check("rst_a_done", 32'(done_a), 32'd0);
    check("rst_a_rd_en", 32'(rd_en_a), 32'd0);
    check("rst_a_addr", 32'(addr_a), 32'h00);
    check("rst_b_valid", 32'(valid_b), 32'd0);
    check("rst_c_addr", 32'(addr_c), 32'h10);
    check("rst_c_done", 32'(done_c), 32'd0);

    // Reset while a read is in flight
    ready_a = 1'b1;
    if (!busy_a) a_clear();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("abort_issue", 32'(rd_en_a), 32'd1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("abort_valid", 32'(valid_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_pc", 32'(addr_a), 32'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_push", 32'(valid_a), 32'd0);
    end

    // Full range: streaming, a 6-cycle stall, then random ready with a stray start
    ready_a = 1'b1;
    if (!busy_a) a_clear();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (11) tick();
    ready_a = 1'b0;
    repeat (6) tick();
    check("stall_pending", 32'(a_n_iss - a_n_pop), 32'd2);
    check("stall_valid", 32'(valid_a), 32'd1);
    check("stall_no_issue", 32'(rd_en_a), 32'd0);
    for (int i = 0; i < 5000 && !done_a; i++) begin
      ready_a = 1'($urandom_range(0, 1));
      if (i == 20 && !busy_a) a_clear();
      start_a = (i == 20);
      tick();
    end
    start_a = 1'b0;
    check("full_done", 32'(done_a), 32'd1);
    check("full_busy", 32'(busy_a), 32'd0);
    check("full_transfers", 32'(a_n_pop), 32'd256);
    check("full_reads", 32'(a_n_iss), 32'd256);
    ready_a = 1'b1;
    repeat (4) tick();
    check("full_no_wrap", 32'(a_n_iss), 32'd256);
    check("full_idle_valid", 32'(valid_a), 32'd0);
    check("full_stay_done", 32'(done_a), 32'd1);

    // Short program from IDLE, then restart from DONE
    run_b("b_first");
    run_b("b_restart");

    // Empty range: start goes straight to DONE without reading
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    repeat (3) tick();
    check("empty_done", 32'(done_c), 32'd1);
    check("empty_busy", 32'(busy_c), 32'd0);
    check("empty_valid", 32'(valid_c), 32'd0);
    check("empty_no_read", 32'(c_rd_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
